// File: rtl/pll_lock_supervisor.sv
// Purpose : closes the loop around a PLL: pulses its reset, qualifies lock, gates the system reset.
// Latency : reset release LOCK_STABLE_CYCLES+3 cycles after pll_lock rises; loss seen 3 cycles after it falls.
// Backpr. : none; every input is a level or a pulse, and every output is a registered level.
//
// Ports:
//   clk, rst_n  - 50 MHz board clock, asynchronous active-low reset
//   pll_lock    - raw PLL lock flag (asynchronous to clk, synchronized internally)
//   clr_status  - one-cycle pulse clearing lock_lost / unlock_cnt
//   pll_rst     - active-high PLL reset, high only while re-initialising the PLL
//   sys_rst_n   - active-low reset for the PLL-clocked logic, released only in RUN
//   locked      - qualified lock, high only in RUN
//   lock_lost   - sticky loss-of-lock flag
//   unlock_cnt  - saturating loss-of-lock event counter
//   retry_cnt   - PLL retries spent in the current lock attempt
//   fail        - terminal: PLL never locked within the retry budget
// Optional feature macro: PLL_RELOCK_RETRY_EN (lock timeout + retry + FAIL state).
// Without it WAIT_LOCK waits forever and retry_cnt / fail are tied low.
module pll_lock_supervisor #(
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 500000,
  parameter int PLL_RST_CYCLES      = 16,
  parameter int MAX_RETRY           = 7,
  parameter int CNT_W               = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_lock,
  input  logic       clr_status,
  output logic       pll_rst,
  output logic       sys_rst_n,
  output logic       locked,
  output logic       lock_lost,
  output logic [7:0] unlock_cnt,
  output logic [2:0] retry_cnt,
  output logic       fail
);

  localparam logic [2:0] S_RESET_PLL = 3'd0;
  localparam logic [2:0] S_WAIT_LOCK = 3'd1;
  localparam logic [2:0] S_STABLE    = 3'd2;
  localparam logic [2:0] S_RUN       = 3'd3;
  localparam logic [2:0] S_FAIL      = 3'd4;

  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);

  logic             lock_meta;
  logic             lock_s;
  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             unlock_evt;

`ifdef PLL_RELOCK_RETRY_EN
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [2:0]       MAX_R   = 3'(MAX_RETRY);
  logic [2:0] retry_q;
  logic       fail_q;
`endif

  // Two-flop synchronizer; lock_s is the only lock view used below.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= pll_lock;
      lock_s    <= lock_meta;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_RESET_PLL: if (cnt == RST_LAST) state_nxt = S_WAIT_LOCK;
      S_WAIT_LOCK: begin
        if (lock_s) begin
          state_nxt = S_STABLE;
        end
`ifdef PLL_RELOCK_RETRY_EN
        else if (cnt == TO_LAST) begin
          state_nxt = (retry_q < MAX_R) ? S_RESET_PLL : S_FAIL;
        end
`endif
      end
      S_STABLE: begin
        // A dropout while qualifying is a glitch, not an error: restart the wait.
        if (!lock_s)                state_nxt = S_WAIT_LOCK;
        else if (cnt == STB_LAST)   state_nxt = S_RUN;
      end
      S_RUN:   if (!lock_s) state_nxt = S_WAIT_LOCK;
      S_FAIL:  state_nxt = S_FAIL;
      default: state_nxt = S_RESET_PLL;
    endcase
  end

  assign unlock_evt = (state == S_RUN) && !lock_s;

  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_RESET_PLL;
      cnt       <= '0;
      pll_rst   <= 1'b1;
      sys_rst_n <= 1'b0;
      locked    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) begin
        cnt <= '0;
      end else if (state != S_RUN && state != S_FAIL) begin
        cnt <= cnt + CNT_W'(1);
      end
      pll_rst   <= (state_nxt == S_RESET_PLL);
      sys_rst_n <= (state_nxt == S_RUN);
      locked    <= (state_nxt == S_RUN);
    end
  end

  // A loss event overrides a coincident clear so the event is never lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_lost  <= 1'b0;
      unlock_cnt <= 8'd0;
    end else if (unlock_evt) begin
      lock_lost <= 1'b1;
      if (clr_status)               unlock_cnt <= 8'd1;
      else if (unlock_cnt != 8'hFF) unlock_cnt <= unlock_cnt + 8'd1;
    end else if (clr_status) begin
      lock_lost  <= 1'b0;
      unlock_cnt <= 8'd0;
    end
  end

`ifdef PLL_RELOCK_RETRY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retry_q <= 3'd0;
      fail_q  <= 1'b0;
    end else begin
      if (state_nxt == S_RUN) begin
        retry_q <= 3'd0;
      end else if (state == S_WAIT_LOCK && state_nxt == S_RESET_PLL) begin
        retry_q <= retry_q + 3'd1;
      end
      fail_q <= (state_nxt == S_FAIL);
    end
  end

  assign retry_cnt = retry_q;
  assign fail      = fail_q;
`else
  logic unused_cfg;
  assign unused_cfg = ^{32'(LOCK_TIMEOUT_CYCLES), 32'(MAX_RETRY)};
  assign retry_cnt  = 3'd0;
  assign fail       = 1'b0;
`endif

endmodule

// File: doc/pll_lock_supervisor.md
# pll_lock_supervisor

Consumes the PLL `pll_lock` output and drives the PLL reset input, closing the control loop around the PLL. Runs on the 50 MHz board clock that also feeds the PLL `clkin1`. Qualifies lock with a stability window before releasing the system reset to downstream logic. Detects and counts loss-of-lock events, and (optionally) retries the PLL on lock timeout.

## Interface
- `LOCK_STABLE_CYCLES`, default 1024: number of consecutive synchronized-lock cycles required before reset release.
- `LOCK_TIMEOUT_CYCLES`, default 500000: maximum cycles spent in WAIT_LOCK before a timeout (10 ms at 50 MHz).
- `PLL_RST_CYCLES`, default 16: width of the `pll_rst` pulse, in cycles.
- `MAX_RETRY`, default 7: number of PLL reset retries before entering FAIL. Range 1..7.
- `CNT_W`, default 20: width of the shared cycle counter. Must satisfy 2^CNT_W > max(LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES).

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: 50 MHz board clock.
- `rst_n` in 1: asynchronous active-low reset.
- `pll_lock` in 1: PLL lock flag. Asynchronous to `clk`.
- `clr_status` in 1: single-cycle pulse that clears `lock_lost` and `unlock_cnt`.
- `pll_rst` out 1: active-high reset to the PLL.
- `sys_rst_n` out 1: active-low reset to the PLL-clocked logic.
- `locked` out 1: qualified-lock indicator.
- `lock_lost` out 1: sticky flag, set by any loss of lock while in RUN.
- `unlock_cnt` out 8: count of loss-of-lock events, saturating.
- `retry_cnt` out 3: number of PLL retries in the current lock attempt.
- `fail` out 1: PLL never locked; terminal state.

## Operation
- `pll_lock` passes through a 2-flop synchronizer to produce `lock_s`. `lock_s` is the only lock signal used inside the block.
- FSM states: RESET_PLL, WAIT_LOCK, STABLE, RUN, FAIL. One counter `cnt` is used by all states and is cleared on every state transition.
- **RESET_PLL**
  - `pll_rst`=1.
  - Exits to WAIT_LOCK when `cnt` = PLL_RST_CYCLES-1.
- **WAIT_LOCK**
  - If `lock_s`=1, go to STABLE.
  - Otherwise `cnt` increments each cycle.
  - When `cnt` = LOCK_TIMEOUT_CYCLES-1, a timeout occurs (see Configuration).
- **STABLE**
  - If `lock_s`=0 (glitch), go to WAIT_LOCK. No error flag is set.
  - When `cnt` = LOCK_STABLE_CYCLES-1, go to RUN.
- **RUN**
  - `sys_rst_n`=1 and `locked`=1.
  - `retry_cnt` is cleared on entry.
  - If `lock_s`=0: set `lock_lost`=1, increment `unlock_cnt` (saturating at 255), and go to WAIT_LOCK.
- **FAIL**
  - `fail`=1, `pll_rst`=0, `sys_rst_n`=0.
  - Exits only on `rst_n`.
- In every state other than RUN: `sys_rst_n`=0 and `locked`=0.
- `pll_rst`=1 only in RESET_PLL.
- All outputs are registered, with no combinational path from inputs to outputs.
- If `clr_status` and an unlock event occur in the same cycle, the event wins: `lock_lost`=1 and `unlock_cnt`=1.
- `clr_status` has no effect on `retry_cnt` or `fail`.

## Timing
- Reset values:
  - state = RESET_PLL, `cnt`=0
  - `pll_rst`=1, `sys_rst_n`=0, `locked`=0
  - `lock_lost`=0, `unlock_cnt`=0, `retry_cnt`=0, `fail`=0
  - synchronizer flops = 0
- After `rst_n` deasserts, `pll_rst` stays high for exactly PLL_RST_CYCLES cycles.
- Lock acquisition: `sys_rst_n` and `locked` rise LOCK_STABLE_CYCLES+3 cycles after a `pll_lock` rising edge, provided `pll_lock` stays high for that whole interval. The 3 extra cycles are 2 synchronizer cycles plus 1 WAIT_LOCK→STABLE cycle.
- Lock loss: `sys_rst_n` and `locked` fall 3 cycles after a `pll_lock` falling edge. `lock_lost` and `unlock_cnt` update on that same edge.
- A `pll_lock` low pulse of 1 cycle or less may be missed by the synchronizer. This is acceptable.
- Asserting `rst_n` mid-operation forces all reset values immediately, including in FAIL.

## Configuration
- Macro: `PLL_RELOCK_RETRY_EN`.
- **Defined:** on a WAIT_LOCK timeout:
  - if `retry_cnt` < MAX_RETRY, increment `retry_cnt` and go to RESET_PLL;
  - otherwise go to FAIL.
- **Undefined:**
  - No timeout: WAIT_LOCK waits indefinitely.
  - FAIL is unreachable.
  - `retry_cnt` and `fail` are tied to 0.
  - `LOCK_TIMEOUT_CYCLES` is unused.

## Test plan
All scenarios use LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=64, PLL_RST_CYCLES=4, MAX_RETRY=2.
- **Reset and lock:** release `rst_n`, hold `pll_lock`=1 from cycle 10.
  - `pll_rst` is high for cycles 0-3.
  - `sys_rst_n` and `locked` rise at cycle 21.
- **Glitch during STABLE:** `pll_lock` high, then low for 3 cycles after 5 high cycles, then high.
  - `sys_rst_n` stays 0 until 8 stable cycles have accumulated after the re-rise.
  - `lock_lost`=0.
- **Loss in RUN:** drop `pll_lock` for 10 cycles, then restore it.
  - `sys_rst_n` falls 3 cycles after the drop.
  - `lock_lost`=1 and `unlock_cnt`=1.
  - Re-release occurs 11 cycles after restore.
- **Saturation and clear:** 260 loss events → `unlock_cnt`=255. Then:
  - `clr_status` alone → `unlock_cnt`=0 and `lock_lost`=0.
  - `clr_status` in the same cycle as a loss → `unlock_cnt`=1.
- **Retry exhaustion** (macro defined): `pll_lock`=0 forever.
  - Three `pll_rst` pulses, 64+4 cycles apart.
  - `retry_cnt` reaches 2, then `fail`=1 and the block stays in FAIL until `rst_n`.
- **No retry** (macro undefined): `pll_lock`=0 for 1000 cycles.
  - A single `pll_rst` pulse only.
  - `fail`=0 and `retry_cnt`=0.
  - Raising `pll_lock` afterwards still produces reset release.
